led_sched_ctrl: RTL and testbench
=================================

Name: led_sched_ctrl

Overview:
Controller that sequences the 4-LED bank on the board through selectable display modes. Modes are OFF, flow-left, flow-right and blink. It contains a speed-scalable step-tick prescaler, a mode state machine advanced by a key pulse, and pause control. It sits between the debounced key logic and the LED pins, and replaces the fixed single-pattern LED driver.

Parameters:
CNT_MAX, 25'd24_999_999, base prescaler terminal count (one step per CNT_MAX+1 clocks at speed 0)
LED_W, 4, LED bank width (fixed at 4; other values unsupported)

Ports:
sys_clk  input  1  system clock
sys_rst  input  1  asynchronous, active-high reset
key_mode  input  1  single-cycle pulse from the debouncer; advances the mode
key_pause  input  1  single-cycle pulse; toggles pause
speed  input  2  step rate select; terminal = CNT_MAX >> speed (0 slowest, 3 fastest)
led_out  output  4  LED drive, active-low (0 = LED lit)
mode_out  output  3  current mode code, for status/debug
tick_out  output  1  one-cycle pulse on each step tick

Behaviour:
- Reset (asynchronous, active-high), all outputs registered:
  - led_out = 4'b1111 (all dark), mode_out = 3'd0 (OFF), tick_out = 0.
  - Internal: prescaler cnt = 0, paused = 0, pattern = 4'b0000.
- Prescaler:
  - term = CNT_MAX >> speed, evaluated every cycle.
  - When not paused: cnt counts 0..term. At cnt == term, cnt goes to 0 and tick_out = 1 for exactly one cycle.
  - If speed changes so that cnt > term, cnt clears to 0 next cycle with no tick.
- Pause:
  - key_pause toggles paused. While paused, cnt and pattern hold and no ticks are issued. Resume continues from the held cnt.
  - In OFF mode, pause still toggles, but the output is unaffected.
- Mode FSM (mode_out codes):
  - States: OFF=0, FLOW_L=1, FLOW_R=2, BLINK=3.
  - key_mode advances OFF -> FLOW_L -> FLOW_R -> BLINK -> OFF.
  - On every mode change, next cycle: pattern loads the new mode's initial value and cnt clears to 0. Pause state is unchanged.
- Patterns (active-high internally; led_out = ~pattern):
  - OFF: 0000; ticks still counted but ignored.
  - FLOW_L: init 0001; each tick shifts left; 1000 wraps to 0001.
  - FLOW_R: init 1000; each tick shifts right; 0001 wraps to 1000.
  - BLINK: init 1111; each tick toggles 1111 <-> 0000.
- Latency: led_out changes on the cycle after the tick_out pulse, and on the cycle after key_mode.
- Simultaneous events:
  - key_mode and tick in the same cycle: mode change wins; the tick is discarded for the pattern but tick_out still pulses.
  - key_mode and key_pause together: both take effect.
- Illegal mode_out codes (e.g. 4–7 without the optional feature) recover to OFF on the next cycle.

Optional Feature:
LED_SCHED_BOUNCE_EN
- Defined:
  - Adds mode BOUNCE=4, inserted after BLINK: BLINK -> BOUNCE -> OFF.
  - Pattern init 0001 with direction left. Ticks step 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010, …
  - Direction reverses at either end; the end LED is never shown twice in a row.
- Undefined: BLINK -> OFF; code 4 is treated as illegal.

Decomposition:
- Shared package led_pkg holds:
  - mode encodings (MODE_OFF, MODE_FLOW_L, MODE_FLOW_R, MODE_BLINK, MODE_BOUNCE)
  - pattern init constants (PAT_FLOW_L_INIT = 4'b0001, PAT_FLOW_R_INIT = 4'b1000, PAT_BLINK_INIT = 4'b1111)
  - default CNT_MAX
- One sub-module: led_tick_gen, containing the prescaler with speed shift, pause hold, and clear-on-mode-change. The FSM and pattern register stay in the top.

Test Plan:
1. CNT_MAX=3, speed=0, reset released, one key_mode -> mode_out=1, led_out=1110; after 4 clocks tick, led_out=1101; after 16 clocks led_out back to 1110 (wrap).
2. Four key_mode pulses spaced 10 clocks apart -> mode_out 1, 2, 3, 0. In FLOW_R the first led_out is 0111 and the next step is 1011. In BLINK led_out alternates 0000/1111 per tick. In OFF led_out=1111.
3. FLOW_L, key_pause at step 0010 -> no tick_out and led_out frozen at 1101 for 50 clocks. Second key_pause -> steps resume from 0010 to 0100.
4. CNT_MAX=15, speed 0 with cnt=10, then speed set to 2 (term=3) -> cnt clears, no tick that cycle; subsequent ticks every 4 clocks.
5. key_mode asserted on the same cycle as tick in FLOW_L -> tick_out=1; pattern becomes FLOW_R init 1000 (led_out=0111), not a shifted FLOW_L value. Assert sys_rst mid-stream -> led_out=1111 and mode_out=0 immediately, before the next clock edge.
6. With LED_SCHED_BOUNCE_EN, mode BOUNCE, CNT_MAX=1 -> led_out sequence 1110, 1101, 1011, 0111, 1011, 1101, 1110, 1101. Without the macro, BLINK + key_mode -> mode_out=0.

Source files
------------

// File: rtl/led_pkg.sv
// Shared definitions for the LED scheduler: mode encodings, pattern seeds,
// default prescaler terminal count and the mode-sequencing helpers.
package led_pkg;

  typedef enum logic [2:0] {
    MODE_OFF    = 3'd0,
    MODE_FLOW_L = 3'd1,
    MODE_FLOW_R = 3'd2,
    MODE_BLINK  = 3'd3,
    MODE_BOUNCE = 3'd4
  } mode_t;

  localparam logic [24:0] DEFAULT_CNT_MAX = 25'd24_999_999;

  localparam logic [3:0] PAT_OFF         = 4'b0000;
  localparam logic [3:0] PAT_FLOW_L_INIT = 4'b0001;
  localparam logic [3:0] PAT_FLOW_R_INIT = 4'b1000;
  localparam logic [3:0] PAT_BLINK_INIT  = 4'b1111;
  localparam logic [3:0] PAT_BOUNCE_INIT = 4'b0001;

  // Mode ring; any code outside the ring falls back to OFF.
  function automatic mode_t next_mode(input mode_t m);
    mode_t n;
    case (m)
      MODE_OFF:    n = MODE_FLOW_L;
      MODE_FLOW_L: n = MODE_FLOW_R;
      MODE_FLOW_R: n = MODE_BLINK;
`ifdef LED_SCHED_BOUNCE_EN
      MODE_BLINK:  n = MODE_BOUNCE;
      MODE_BOUNCE: n = MODE_OFF;
`else
      MODE_BLINK:  n = MODE_OFF;
`endif
      default:     n = MODE_OFF;
    endcase
    return n;
  endfunction

  function automatic logic [3:0] init_pattern(input mode_t m);
    logic [3:0] p;
    case (m)
      MODE_FLOW_L: p = PAT_FLOW_L_INIT;
      MODE_FLOW_R: p = PAT_FLOW_R_INIT;
      MODE_BLINK:  p = PAT_BLINK_INIT;
`ifdef LED_SCHED_BOUNCE_EN
      MODE_BOUNCE: p = PAT_BOUNCE_INIT;
`endif
      default:     p = PAT_OFF;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/led_sched_ctrl_if.sv
// Key/status bundle between the key debouncer side and the LED scheduler.
interface led_sched_ctrl_if;

  logic       key_mode;
  logic       key_pause;
  logic [1:0] speed;
  logic [3:0] led_out;
  logic [2:0] mode_out;
  logic       tick_out;

  modport master (
    output key_mode, key_pause, speed,
    input  led_out, mode_out, tick_out
  );

  modport slave (
    input  key_mode, key_pause, speed,
    output led_out, mode_out, tick_out
  );

endinterface

// File: rtl/led_tick_gen.sv
// Step-tick prescaler: terminal count scales with speed, holds while paused,
// and restarts from zero whenever the mode changes.
module led_tick_gen
  import led_pkg::*;
#(
  parameter logic [24:0] CNT_MAX = DEFAULT_CNT_MAX
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] speed,
  input  logic       hold,
  input  logic       clear,
  output logic       tick
);

  logic [24:0] cnt;
  logic [24:0] term;

  assign term = CNT_MAX >> speed;

  // A speed change that leaves cnt beyond the new terminal restarts the count
  // without emitting a tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (clear) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (hold) begin
      tick <= 1'b0;
    end else if (cnt > term) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == term) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + 25'd1;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/led_sched_ctrl.sv
// LED bank scheduler: mode FSM, pattern register and pause control around the
// step-tick prescaler. Define LED_SCHED_BOUNCE_EN to add the BOUNCE mode.
module led_sched_ctrl
  import led_pkg::*;
#(
  parameter logic [24:0] CNT_MAX = DEFAULT_CNT_MAX,
  parameter int          LED_W   = 4
) (
  input  logic           sys_clk,
  input  logic           sys_rst,
  led_sched_ctrl_if.slave bus
);

  mode_t            mode;
  logic [LED_W-1:0] pattern;
  logic             paused;
  logic             hold;
  logic             tick;
`ifdef LED_SCHED_BOUNCE_EN
  logic             dir_left;
`endif

  // Using the post-toggle pause state makes the press edge itself take effect.
  assign hold = paused ^ bus.key_pause;

  led_tick_gen #(
    .CNT_MAX (CNT_MAX)
  ) u_tick_gen (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .speed (bus.speed),
    .hold  (hold),
    .clear (bus.key_mode),
    .tick  (tick)
  );

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      paused <= 1'b0;
    end else if (bus.key_pause) begin
      paused <= ~paused;
    end
  end

  // A mode change always beats a coincident tick for the pattern register.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      mode     <= MODE_OFF;
      pattern  <= PAT_OFF;
`ifdef LED_SCHED_BOUNCE_EN
      dir_left <= 1'b1;
`endif
    end else if (bus.key_mode) begin
      mode     <= next_mode(mode);
      pattern  <= init_pattern(next_mode(mode));
`ifdef LED_SCHED_BOUNCE_EN
      dir_left <= 1'b1;
`endif
    end else begin
      case (mode)
        MODE_OFF: begin
          pattern <= PAT_OFF;
        end
        MODE_FLOW_L: begin
          if (tick) pattern <= {pattern[LED_W-2:0], pattern[LED_W-1]};
        end
        MODE_FLOW_R: begin
          if (tick) pattern <= {pattern[0], pattern[LED_W-1:1]};
        end
        MODE_BLINK: begin
          if (tick) pattern <= ~pattern;
        end
`ifdef LED_SCHED_BOUNCE_EN
        MODE_BOUNCE: begin
          if (tick) begin
            if (dir_left) begin
              if (pattern[LED_W-1]) begin
                pattern  <= pattern >> 1;
                dir_left <= 1'b0;
              end else begin
                pattern  <= pattern << 1;
              end
            end else begin
              if (pattern[0]) begin
                pattern  <= pattern << 1;
                dir_left <= 1'b1;
              end else begin
                pattern  <= pattern >> 1;
              end
            end
          end
        end
`endif
        default: begin
          mode    <= MODE_OFF;
          pattern <= PAT_OFF;
        end
      endcase
    end
  end

  assign bus.led_out  = ~pattern;
  assign bus.mode_out = mode;
  assign bus.tick_out = tick;

endmodule

// File: tb/tb_led_sched_ctrl.sv
// Directed self-checking bench for led_sched_ctrl (two instances: CNT_MAX=3 and 15).
module tb_led_sched_ctrl;

  logic sys_clk = 1'b0;
  logic sys_rst;

  int checks_total  = 0;
  int checks_passed = 0;

  always #5 sys_clk = ~sys_clk;

  led_sched_ctrl_if if_a ();
  led_sched_ctrl_if if_b ();

  led_sched_ctrl #(
    .CNT_MAX (25'd3),
    .LED_W   (4)
  ) dut_a (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (if_a.slave)
  );

  led_sched_ctrl #(
    .CNT_MAX (25'd15),
    .LED_W   (4)
  ) dut_b (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (if_b.slave)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic stepN(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input int sel, input logic km, input logic kp);
    if (sel == 0) begin
      if_a.key_mode  = km;
      if_a.key_pause = kp;
    end else begin
      if_b.key_mode  = km;
      if_b.key_pause = kp;
    end
    stepN(1);
    if_a.key_mode  = 1'b0;
    if_a.key_pause = 1'b0;
    if_b.key_mode  = 1'b0;
    if_b.key_pause = 1'b0;
  endtask

  task automatic waitTickA(input int limit, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      if (if_a.tick_out === 1'b1) seen = 1'b1;
      else stepN(1);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit          seen;
    int          tick_count;
    logic [3:0]  bounce_exp [7];

    bounce_exp = '{4'b1101, 4'b1011, 4'b0111, 4'b1011, 4'b1101, 4'b1110, 4'b1101};

    if_a.key_mode = 1'b0; if_a.key_pause = 1'b0; if_a.speed = 2'd0;
    if_b.key_mode = 1'b0; if_b.key_pause = 1'b0; if_b.speed = 2'd0;
    sys_rst = 1'b1;
    #12;
    checkOutput("reset led_out",  if_a.led_out,  4'b1111);
    checkOutput("reset mode_out", if_a.mode_out, 3'd0);
    checkOutput("reset tick_out", if_a.tick_out, 1'b0);
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
    stepN(2);

    // Pause in OFF leaves the dark bank alone
    applyStimulus(0, 1'b0, 1'b1);
    stepN(6);
    checkOutput("off paused led", if_a.led_out, 4'b1111);
    applyStimulus(0, 1'b0, 1'b1);

    // Test 1: FLOW_L stepping and wrap
    applyStimulus(0, 1'b1, 1'b0);
    checkOutput("t1 mode", if_a.mode_out, 3'd1);
    checkOutput("t1 led init", if_a.led_out, 4'b1110);
    stepN(3);
    checkOutput("t1 no early tick", if_a.tick_out, 1'b0);
    stepN(1);
    checkOutput("t1 tick", if_a.tick_out, 1'b1);
    checkOutput("t1 led before step", if_a.led_out, 4'b1110);
    stepN(1);
    checkOutput("t1 led step1", if_a.led_out, 4'b1101);
    checkOutput("t1 tick one cycle", if_a.tick_out, 1'b0);
    stepN(12);
    checkOutput("t1 led wrap", if_a.led_out, 4'b1110);

    // Test 2: FLOW_R, BLINK, then next mode
    applyStimulus(0, 1'b1, 1'b0);
    checkOutput("t2 mode flow_r", if_a.mode_out, 3'd2);
    checkOutput("t2 flow_r init", if_a.led_out, 4'b0111);
    stepN(5);
    checkOutput("t2 flow_r step", if_a.led_out, 4'b1011);
    applyStimulus(0, 1'b1, 1'b0);
    checkOutput("t2 mode blink", if_a.mode_out, 3'd3);
    checkOutput("t2 blink init", if_a.led_out, 4'b0000);
    stepN(5);
    checkOutput("t2 blink step1", if_a.led_out, 4'b1111);
    stepN(4);
    checkOutput("t2 blink step2", if_a.led_out, 4'b0000);
    applyStimulus(0, 1'b1, 1'b0);
`ifdef LED_SCHED_BOUNCE_EN
    checkOutput("t6 mode bounce", if_a.mode_out, 3'd4);
    checkOutput("t6 bounce init", if_a.led_out, 4'b1110);
    stepN(5);
    checkOutput("t6 bounce 0", if_a.led_out, bounce_exp[0]);
    for (int i = 1; i < 7; i++) begin
      stepN(4);
      checkOutput($sformatf("t6 bounce %0d", i), if_a.led_out, bounce_exp[i]);
    end
    applyStimulus(0, 1'b1, 1'b0);
`endif
    checkOutput("t2 mode off", if_a.mode_out, 3'd0);
    checkOutput("t2 led off", if_a.led_out, 4'b1111);

    // Test 3: pause and resume in FLOW_L
    applyStimulus(0, 1'b1, 1'b0);
    stepN(5);
    checkOutput("t3 led before pause", if_a.led_out, 4'b1101);
    applyStimulus(0, 1'b0, 1'b1);
    tick_count = 0;
    for (int i = 0; i < 50; i++) begin
      stepN(1);
      if (if_a.tick_out === 1'b1) tick_count++;
    end
    checkOutput("t3 paused ticks", tick_count, 0);
    checkOutput("t3 paused led", if_a.led_out, 4'b1101);
    applyStimulus(0, 1'b0, 1'b1);
    stepN(2);
    checkOutput("t3 resume tick", if_a.tick_out, 1'b1);
    stepN(1);
    checkOutput("t3 resume led", if_a.led_out, 4'b1011);

    // Test 5: key_mode in the tick cycle, then async reset
    waitTickA(20, seen);
    checkOutput("t5 tick seen", seen, 1'b1);
    applyStimulus(0, 1'b1, 1'b0);
    checkOutput("t5 mode", if_a.mode_out, 3'd2);
    checkOutput("t5 led init wins", if_a.led_out, 4'b0111);
    #3;
    sys_rst = 1'b1;
    #1;
    checkOutput("t5 async led", if_a.led_out, 4'b1111);
    checkOutput("t5 async mode", if_a.mode_out, 3'd0);
    #4;
    sys_rst = 1'b0;
    stepN(1);

    // Test 4: speed change drops cnt past the new terminal
    applyStimulus(1, 1'b1, 1'b0);
    stepN(10);
    if_b.speed = 2'd2;
    stepN(1);
    checkOutput("t4 no tick on clear", if_b.tick_out, 1'b0);
    stepN(3);
    checkOutput("t4 no tick early", if_b.tick_out, 1'b0);
    stepN(1);
    checkOutput("t4 tick after 4", if_b.tick_out, 1'b1);
    stepN(1);
    checkOutput("t4 tick one cycle", if_b.tick_out, 1'b0);
    checkOutput("t4 led step", if_b.led_out, 4'b1101);
    stepN(3);
    checkOutput("t4 next tick", if_b.tick_out, 1'b1);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
